// File: rtl/afisare_pkg.sv
// Shared types and helpers for the afisare display feeder.
package afisare_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_DEPTH       = 10;
    localparam int DEF_HOLD_CYCLES = 4;

    // Bits needed to index n entries (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/afisare_word_mem.sv
// Word buffer for the afisare feeder: synchronous write, combinational read.
module afisare_word_mem
    import afisare_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i <= LAST_IDX)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range indices read as zero instead of indexing past the array.
    always_comb begin
        rdata_o = '0;
        if (raddr_i <= LAST_IDX) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/afisare_feeder.sv
// afisare_feeder: buffers up to DEPTH words and plays them out to the display
// over out_valid/out_ready, dwelling HOLD_CYCLES clocks after each accepted word.
// Optional macro AFISARE_FEEDER_LOOP_EN adds a 'loop' input that wraps playback.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | accept loads / clear, wait for start
// ST_PRESENT | out_valid high with mem[rd_ptr], wait for out_ready
// ST_HOLD    | word accepted, dwell counter running, out_data held
// ST_DONE    | one-cycle done pulse, then back to idle
module afisare_feeder
    import afisare_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       start,
    input  logic                       stop,
`ifdef AFISARE_FEEDER_LOOP_EN
    input  logic                       loop,
`endif
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PTR_W  = idx_width(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HOLD_W = idx_width(HOLD_CYCLES);

    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, ptr_next;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  count_q, count_d, last_idx;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_rdata;
    logic              is_last;
    logic              loop_en;

`ifdef AFISARE_FEEDER_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign last_idx = count_q - CNT_W'(1);
    assign is_last  = (CNT_W'(rd_ptr_q) == last_idx);

    // Index of the word that would be presented next; kept out of the FSM
    // process so the memory read does not loop back through it.
    assign ptr_next = (state_q == ST_HOLD && !is_last) ? rd_ptr_q + PTR_W'(1) : '0;

    afisare_word_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (count_q[PTR_W-1:0]),
        .wdata_i (wr_data),
        .raddr_i (ptr_next),
        .rdata_o (mem_rdata)
    );

    // Next-state, buffer bookkeeping and registered output staging.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        hold_d      = hold_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    // A start alongside clr is dropped: the buffer is emptied.
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    if (wr_en) begin
                        if (count_q < FULL) begin
                            mem_we  = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (start && (count_q != '0)) begin
                        rd_ptr_d    = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = mem_rdata;
                        state_d     = ST_PRESENT;
                    end
                end
            end

            ST_PRESENT: begin
                if (stop) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    hold_d      = HOLD_LOAD;
                    state_d     = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (stop) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (is_last && !loop_en) begin
                    state_d = ST_DONE;
                end else begin
                    rd_ptr_d    = ptr_next;
                    out_valid_d = 1'b1;
                    out_data_d  = mem_rdata;
                    state_d     = ST_PRESENT;
                end
            end

            ST_DONE: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            hold_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_q      <= hold_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    // A stop arriving in DONE suppresses the pulse.
    assign done      = (state_q == ST_DONE) && !stop;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_afisare_feeder.sv
// Self-checking bench for afisare_feeder (WIDTH=32, DEPTH=10, HOLD_CYCLES=4).
module tb_afisare_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
`ifdef AFISARE_FEEDER_LOOP_EN
    logic        loop = 1'b0;
`endif
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  count;
    logic        overflow;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [31:0] sb[$];
    int          hs_cyc[$];
    int          done_cyc[$];

    afisare_feeder #(
        .WIDTH       (32),
        .DEPTH       (10),
        .HOLD_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
`ifdef AFISARE_FEEDER_LOOP_EN
        .loop      (loop),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: a handshake is decided by the values in front of the edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready && !stop) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL sb_unexpected: got word 0x%08h, expected no transfer", out_data);
                end else begin
                    chk("sb_word", 64'(out_data), 64'(sb.pop_front()));
                end
            end
            if (done) done_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        hs_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic load_word(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_hs(input int k, input int budget, input string nm);
        int n = 0;
        while (hs_cyc.size() < k && n < budget) begin
            step();
            n++;
        end
        chk({nm, "_hs_timeout"}, 64'(hs_cyc.size() >= k), 64'(1));
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            step();
            n++;
        end
        chk({nm, "_done_timeout"}, 64'(done_cyc.size() > 0), 64'(1));
        repeat (3) step();
    endtask

    typedef struct {
        logic        clr;
        logic        wr_en;
        logic        start;
        logic [31:0] wdata;
        logic [3:0]  e_count;
        logic        e_ovf;
    } vec_t;

    vec_t vt[16];

    task automatic apply_vec(input int i);
        clr     = vt[i].clr;
        wr_en   = vt[i].wr_en;
        start   = vt[i].start;
        wr_data = vt[i].wdata;
        step();
        chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].e_count));
        chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vt[i].e_ovf));
        chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(0));
        chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(0));
        clr   = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int rc;
        logic [31:0] w5 [5];

        // Table: clear, ten good writes, one dropped write; then clear/empty-start.
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0};
        for (int i = 1; i <= 10; i++)
            vt[i] = '{1'b0, 1'b1, 1'b0, 32'hA000_0000 + 32'(i), 4'(i), 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 32'hBADB_AD11, 4'd10, 1'b1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 32'h0, 4'd10, 1'b1};
        vt[13] = '{1'b1, 1'b1, 1'b0, 32'h5555_5555, 4'd0, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b1, 32'h0, 4'd0, 1'b0};
        vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0};

        // Reset values while rst_n is held low.
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        #19 rst_n = 1'b1;
        step();

        // Three words, ready tied high.
        clear_hist();
        out_ready = 1'b1;
        load_word(32'h1111_1111);
        load_word(32'h2222_2222);
        load_word(32'h3333_3333);
        chk("t1_count_loaded", 64'(count), 64'(3));
        sb.push_back(32'h1111_1111);
        sb.push_back(32'h2222_2222);
        sb.push_back(32'h3333_3333);
        start_pulse();
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_first_valid", 64'(out_valid), 64'(1));
        wait_done(100, "t1");
        chk("t1_hs_count", 64'(hs_cyc.size()), 64'(3));
        if (hs_cyc.size() == 3) begin
            chk("t1_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'(5));
            chk("t1_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'(5));
            if (done_cyc.size() > 0)
                chk("t1_done_delay", 64'(done_cyc[0] - hs_cyc[2]), 64'(5));
        end
        chk("t1_done_pulses", 64'(done_cyc.size()), 64'(1));
        chk("t1_count_kept", 64'(count), 64'(3));
        chk("t1_idle", 64'(busy), 64'(0));
        chk("t1_sb_empty", 64'(sb.size()), 64'(0));

        // Fill past capacity; the dropped 11th word must never play out.
        clear_hist();
        for (int i = 0; i <= 11; i++) apply_vec(i);
        for (int i = 1; i <= 10; i++) sb.push_back(vt[i].wdata);
        start_pulse();
        wait_done(200, "t2");
        chk("t2_hs_count", 64'(hs_cyc.size()), 64'(10));
        chk("t2_done_pulses", 64'(done_cyc.size()), 64'(1));
        chk("t2_sb_empty", 64'(sb.size()), 64'(0));
        clear_hist();
        for (int i = 12; i <= 15; i++) apply_vec(i);
        repeat (3) step();
        chk("t3_no_done", 64'(done_cyc.size()), 64'(0));
        chk("t3_no_hs", 64'(hs_cyc.size()), 64'(0));

        // Back-pressure: ready low for 7 PRESENT cycles.
        clear_hist();
        out_ready = 1'b0;
        load_word(32'hDEAD_BEEF);
        sb.push_back(32'hDEAD_BEEF);
        start_pulse();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t4_valid_c%0d", i), 64'(out_valid), 64'(1));
            chk($sformatf("t4_data_c%0d", i), 64'(out_data), 64'(32'hDEAD_BEEF));
            step();
        end
        chk("t4_no_early_hs", 64'(hs_cyc.size()), 64'(0));
        out_ready = 1'b1;
        rc = cyc;
        wait_hs(1, 5, "t4");
        if (hs_cyc.size() > 0) chk("t4_hs_on_first_ready", 64'(hs_cyc[0]), 64'(rc));
        chk("t4_hold_valid_low", 64'(out_valid), 64'(0));
        chk("t4_hold_data", 64'(out_data), 64'(32'hDEAD_BEEF));
        wait_done(50, "t4");
        chk("t4_sb_empty", 64'(sb.size()), 64'(0));

        // Stop in the HOLD after the second word of five, then replay.
        clear_hist();
        do_clr();
        for (int i = 0; i < 5; i++) begin
            w5[i] = 32'hC0DE_0000 + 32'(i);
            load_word(w5[i]);
        end
        sb.push_back(w5[0]);
        sb.push_back(w5[1]);
        start_pulse();
        wait_hs(2, 50, "t5");
        chk("t5_in_hold", 64'(busy && !out_valid), 64'(1));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t5_stopped_busy", 64'(busy), 64'(0));
        chk("t5_stopped_valid", 64'(out_valid), 64'(0));
        repeat (8) step();
        chk("t5_no_done", 64'(done_cyc.size()), 64'(0));
        chk("t5_no_more_hs", 64'(hs_cyc.size()), 64'(2));
        clear_hist();
        for (int i = 0; i < 5; i++) sb.push_back(w5[i]);
        start_pulse();
        wait_done(100, "t5r");
        chk("t5_replay_hs", 64'(hs_cyc.size()), 64'(5));
        chk("t5_replay_sb_empty", 64'(sb.size()), 64'(0));

        // Asynchronous reset in the middle of PRESENT.
        clear_hist();
        do_clr();
        out_ready = 1'b0;
        load_word(32'h0123_4567);
        load_word(32'h89AB_CDEF);
        start_pulse();
        chk("t6_present", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_count", 64'(count), 64'(0));
        #3 rst_n = 1'b1;
        step();
        chk("t6_after_count", 64'(count), 64'(0));

`ifdef AFISARE_FEEDER_LOOP_EN
        // Looping two words: word0, word1, word0 with no done.
        clear_hist();
        out_ready = 1'b1;
        load_word(32'hAAAA_0000);
        load_word(32'hAAAA_0001);
        loop = 1'b1;
        sb.push_back(32'hAAAA_0000);
        sb.push_back(32'hAAAA_0001);
        sb.push_back(32'hAAAA_0000);
        start_pulse();
        wait_hs(3, 60, "t7");
        chk("t7_no_done", 64'(done_cyc.size()), 64'(0));
        stop = 1'b1;
        step();
        stop = 1'b0;
        loop = 1'b0;
        chk("t7_stopped", 64'(busy), 64'(0));
        chk("t7_sb_empty", 64'(sb.size()), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard ceiling so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
